// File: rtl/ram_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter_pkg
// Shared definitions for the RAM port arbiter and the memory stages:
//   - default parameter values (word-address width, IF starvation limit)
//   - resp_sel_e : owner of the single outstanding RAM read response
//   - mem_op_e   : memory operation kind used by memory_stage1/2, kept here
//                  so every block that talks to the RAM uses one copy
// ---------------------------------------------------------------------------
package ram_port_arbiter_pkg;

    localparam int ADDR_W_DEFAULT     = 30;
    localparam int STARVE_MAX_DEFAULT = 4;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_IF   = 2'd1,
        RESP_DM   = 2'd2
    } resp_sel_e;

    typedef enum logic [1:0] {
        MEM_OP_NONE = 2'd0,
        MEM_OP_LD   = 2'd1,
        MEM_OP_ST   = 2'd2
    } mem_op_e;

endpackage

// File: rtl/ram_port_arbiter_priority.sv
// ---------------------------------------------------------------------------
// ram_arb_priority
// Picks the single winner of the RAM port each cycle. DM has fixed priority,
// except that after STARVE_MAX consecutive cycles of an eligible-but-denied
// IF request, IF wins one conflict.
// Ports:
//   clk, rst     clock / synchronous active-high reset
//   if_req_i     IF read request
//   if_flush_i   IF flush; an IF request is not eligible while it is high
//   dm_req_i     DM request (any request, including one with no RAM access)
//   if_win_o     IF wins this cycle (combinational)
//   dm_win_o     DM wins this cycle (combinational)
// ---------------------------------------------------------------------------
module ram_arb_priority
    import ram_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req_i,
    input  logic if_flush_i,
    input  logic dm_req_i,
    output logic if_win_o,
    output logic dm_win_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             if_elig;
    logic             starved;

    // A DM request with no enables still occupies the grant slot (it is
    // acknowledged immediately), so it contends with IF like any DM request.
    always_comb begin
        if_elig  = if_req_i & ~if_flush_i;
        starved  = (starve_cnt_q == CNT_W'(STARVE_MAX));
        if_win_o = 1'b0;
        dm_win_o = 1'b0;
        if (!rst) begin
            if (if_elig && (!dm_req_i || starved)) begin
                if_win_o = 1'b1;
            end else if (dm_req_i) begin
                dm_win_o = 1'b1;
            end
        end
    end

    // Counter only grows while IF is actually waiting; any gap clears it.
    always_comb begin
        starve_cnt_d = '0;
        if (if_elig && !if_win_o) begin
            starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
// Shares one single-port word RAM between instruction fetch (IF, read-only)
// and the data memory stage (DM). One access per cycle, fully pipelined;
// RAM read latency is one cycle and the owner of that response is tracked
// in resp_sel_q. Read data is passed through unchanged to both requesters.
// Ports:
//   clk, rst                         clock / synchronous active-high reset
//   if_req_i, if_addr_i, if_flush_i  IF request, word address, flush
//   if_gnt_o, if_rvalid_o, if_rdata_o  IF grant, response valid, data
//   dm_req_i, dm_addr_i, dm_wdata_i, dm_wen_i, dm_ren_i  DM request fields
//   dm_gnt_o, dm_rvalid_o, dm_rdata_o  DM grant, response valid, data
//   ram_addr_o, ram_wdata_o, ram_wen_o, ram_ren_o       RAM drive
//   ram_data_i                       RAM read data (cycle after ram_ren_o)
// ---------------------------------------------------------------------------
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [31:0]       if_rdata_o,
    input  logic              dm_req_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [31:0]       dm_wdata_i,
    input  logic [3:0]        dm_wen_i,
    input  logic              dm_ren_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [31:0]       dm_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    output logic [3:0]        ram_wen_o,
    output logic              ram_ren_o,
    input  logic [31:0]       ram_data_i
);

    resp_sel_e resp_sel_q;
    resp_sel_e resp_sel_d;
    logic      if_win;
    logic      dm_win;
    logic      dm_access;

    ram_arb_priority #(
        .STARVE_MAX (STARVE_MAX)
    ) u_priority (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req_i),
        .if_flush_i (if_flush_i),
        .dm_req_i   (dm_req_i),
        .if_win_o   (if_win),
        .dm_win_o   (dm_win)
    );

    assign if_gnt_o = if_win;
    assign dm_gnt_o = dm_win;

    // RAM mux: the winner drives the port; a DM request with no enables is
    // acknowledged without touching the RAM, so the port stays idle.
    always_comb begin
        dm_access   = dm_req_i & (dm_ren_i | (|dm_wen_i));
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_wen_o   = '0;
        ram_ren_o   = 1'b0;
        if (if_win) begin
            ram_addr_o = if_addr_i;
            ram_ren_o  = 1'b1;
        end else if (dm_win && dm_access) begin
            ram_addr_o  = dm_addr_i;
            ram_wdata_o = dm_wdata_i;
            ram_wen_o   = dm_wen_i;
            ram_ren_o   = dm_ren_i;
        end
    end

    // Next response owner: only reads produce a response.
    always_comb begin
        resp_sel_d = RESP_NONE;
        if (if_win) begin
            resp_sel_d = RESP_IF;
        end else if (dm_win && dm_ren_i) begin
            resp_sel_d = RESP_DM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_sel_q <= RESP_NONE;
        end else begin
            resp_sel_q <= resp_sel_d;
        end
    end

    // Responses are masked during reset so an in-flight read never surfaces;
    // a flush in the response cycle drops the IF data.
    assign if_rvalid_o = ~rst & (resp_sel_q == RESP_IF) & ~if_flush_i;
    assign dm_rvalid_o = ~rst & (resp_sel_q == RESP_DM);
    assign if_rdata_o  = ram_data_i;
    assign dm_rdata_o  = ram_data_i;

endmodule
